// File: rtl/mips16_multicycle_core_if.sv
// Bus bundle for mips16_multicycle_core: run control, instruction load port,
// debug read ports and status outputs.
interface mips16_multicycle_core_if #(
  parameter int DW      = 16,
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8
);
  logic               run;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_waddr;
  logic [15:0]        imem_wdata;
  logic [2:0]         dbg_reg_addr;
  logic [DW-1:0]      dbg_reg_data;
  logic [DMEM_AW-1:0] dbg_dmem_addr;
  logic [DW-1:0]      dbg_dmem_data;
  logic [IMEM_AW-1:0] pc;
  logic               busy;
  logic               halted;
  logic               ovf;
  logic [31:0]        retired;

  modport master (
    output run, imem_we, imem_waddr, imem_wdata, dbg_reg_addr, dbg_dmem_addr,
    input  dbg_reg_data, dbg_dmem_data, pc, busy, halted, ovf, retired
  );

  modport slave (
    input  run, imem_we, imem_waddr, imem_wdata, dbg_reg_addr, dbg_dmem_addr,
    output dbg_reg_data, dbg_dmem_data, pc, busy, halted, ovf, retired
  );
endinterface

// File: rtl/mips16_multicycle_core.sv
// Multi-cycle 16-bit-instruction CPU with internal instruction/data memories.
//
// state   | meaning
// IDLE    | waiting for run after reset; imem loads accepted
// FETCH   | instr <= imem[pc], pc <= pc+1
// DECODE  | latch operand registers and sign-extended imm
// EXECUTE | ALU; BEQ/JMP/HALT complete here
// MEM     | LW reads dmem, SW writes dmem and completes
// WB      | register write-back, completes
// HALTED  | stopped after HALT; imem loads and run accepted
module mips16_multicycle_core #(
  parameter int DW      = 16,
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  mips16_multicycle_core_if.slave     bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALTED
  } state_t;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_LW    = 3'b010;
  localparam logic [2:0] OP_SW    = 3'b011;
  localparam logic [2:0] OP_BEQ   = 3'b100;
  localparam logic [2:0] OP_JMP   = 3'b101;
  localparam logic [2:0] OP_SLT   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  state_t state, state_nxt;

  logic [15:0]        imem [2**IMEM_AW];
  logic [DW-1:0]      dmem [2**DMEM_AW];
  logic [DW-1:0]      regs [8];

  logic [15:0]        instr;
  logic [IMEM_AW-1:0] pc_q;
  logic [31:0]        retired_q;
  logic               ovf_q;
  logic [DW-1:0]      a_val, b_val, c_val, imm, alu_res, mdr;
  logic [DW-1:0]      alu_nxt, neg_c;
  logic               ovf_hit;
  logic               complete;
  logic               idle_like;
  logic               start;
  logic [2:0]         op;
  logic [1:0]         funct;
  logic [2:0]         ra;

  assign op        = instr[15:13];
  assign funct     = instr[4:3];
  assign ra        = instr[12:10];
  assign idle_like = (state == S_IDLE) || (state == S_HALTED);
  assign start     = idle_like && bus.run;
  assign neg_c     = '0 - c_val;

  assign bus.pc            = pc_q;
  assign bus.retired       = retired_q;
  assign bus.ovf           = ovf_q;
  assign bus.dbg_reg_data  = regs[bus.dbg_reg_addr];
  assign bus.dbg_dmem_data = dmem[bus.dbg_dmem_addr];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALTED: if (bus.run) state_nxt = S_FETCH;
      S_FETCH:          state_nxt = S_DECODE;
      S_DECODE:         state_nxt = S_EXECUTE;
      S_EXECUTE: begin
        case (op)
          OP_BEQ, OP_JMP: state_nxt = S_FETCH;
          OP_HALT:        state_nxt = S_HALTED;
          OP_LW, OP_SW:   state_nxt = S_MEM;
          default:        state_nxt = S_WB;
        endcase
      end
      S_MEM:   state_nxt = (op == OP_LW) ? S_WB : S_FETCH;
      S_WB:    state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy   = 1'b0;
    bus.halted = 1'b0;
    complete   = 1'b0;
    case (state)
      S_FETCH, S_DECODE: bus.busy = 1'b1;
      S_EXECUTE: begin
        bus.busy = 1'b1;
        complete = (op == OP_BEQ) || (op == OP_JMP) || (op == OP_HALT);
      end
      S_MEM: begin
        bus.busy = 1'b1;
        complete = (op == OP_SW);
      end
      S_WB: begin
        bus.busy = 1'b1;
        complete = 1'b1;
      end
      S_HALTED: bus.halted = 1'b1;
      default: ;
    endcase
  end

  // SUB overflow is judged on rB against the negated rC, as an addition.
  always_comb begin
    alu_nxt = '0;
    ovf_hit = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          2'b00: begin
            alu_nxt = b_val + c_val;
            ovf_hit = (b_val[DW-1] == c_val[DW-1]) && (alu_nxt[DW-1] != b_val[DW-1]);
          end
          2'b01: begin
            alu_nxt = b_val + neg_c;
            ovf_hit = (b_val[DW-1] == neg_c[DW-1]) && (alu_nxt[DW-1] != b_val[DW-1]);
          end
          2'b10:   alu_nxt = b_val & c_val;
          default: alu_nxt = b_val | c_val;
        endcase
      end
      OP_ADDI: begin
        alu_nxt = b_val + imm;
        ovf_hit = (b_val[DW-1] == imm[DW-1]) && (alu_nxt[DW-1] != b_val[DW-1]);
      end
      OP_LW, OP_SW: alu_nxt = b_val + imm;
      OP_SLT:       alu_nxt = ($signed(b_val) < $signed(c_val)) ? DW'(1) : '0;
      default:      alu_nxt = '0;
    endcase
  end

  // Datapath and architectural state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= '0;
      retired_q <= '0;
      ovf_q     <= 1'b0;
      instr     <= '0;
      a_val     <= '0;
      b_val     <= '0;
      c_val     <= '0;
      imm       <= '0;
      alu_res   <= '0;
      mdr       <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (start) begin
        pc_q      <= '0;
        retired_q <= '0;
        ovf_q     <= 1'b0;
      end else if (complete) begin
        retired_q <= retired_q + 32'd1;
      end
      case (state)
        S_FETCH: begin
          instr <= imem[pc_q];
          pc_q  <= pc_q + 1'b1;
        end
        S_DECODE: begin
          a_val <= regs[instr[12:10]];
          b_val <= regs[instr[9:7]];
          c_val <= regs[instr[2:0]];
          imm   <= {{(DW-7){instr[6]}}, instr[6:0]};
        end
        S_EXECUTE: begin
          alu_res <= alu_nxt;
          if (ovf_hit) ovf_q <= 1'b1;
          if (op == OP_BEQ && a_val == b_val) pc_q <= pc_q + imm[IMEM_AW-1:0];
          if (op == OP_JMP) pc_q <= IMEM_AW'({{IMEM_AW{1'b0}}, instr[12:0]});
        end
        S_MEM: if (op == OP_LW) mdr <= dmem[alu_res[DMEM_AW-1:0]];
        S_WB:  if (ra != 3'd0) regs[ra] <= (op == OP_LW) ? mdr : alu_res;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (bus.imem_we && idle_like) imem[bus.imem_waddr] <= bus.imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst && state == S_MEM && op == OP_SW) dmem[alu_res[DMEM_AW-1:0]] <= a_val;
  end
endmodule

// File: tb/tb_mips16_multicycle_core.sv
// Directed bench for mips16_multicycle_core: small hand-assembled programs
// with hand-computed register, memory, flag and cycle-count expectations.
module tb_mips16_multicycle_core;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   n;

  mips16_multicycle_core_if bus_if ();

  mips16_multicycle_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] f_i(input logic [2:0] op, input int a, input int b, input int imm);
    logic [6:0] i7;
    i7 = 7'(imm);
    return {op, 3'(a), 3'(b), i7};
  endfunction

  function automatic logic [15:0] f_r(input int fn, input int a, input int b, input int c);
    return {3'b000, 3'(a), 3'(b), 2'b00, 2'(fn), 3'(c)};
  endfunction

  function automatic logic [15:0] f_slt(input int a, input int b, input int c);
    return {3'b110, 3'(a), 3'(b), 4'b0000, 3'(c)};
  endfunction

  localparam logic [15:0] HALT = 16'hE000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input int idx, input logic [31:0] exp);
    bus_if.dbg_reg_addr = 3'(idx);
    #1;
    chk(tag, 32'(bus_if.dbg_reg_data), exp);
  endtask

  task automatic chk_mem(input string tag, input int addr, input logic [31:0] exp);
    bus_if.dbg_dmem_addr = 8'(addr);
    #1;
    chk(tag, 32'(bus_if.dbg_dmem_data), exp);
  endtask

  task automatic put(input int addr, input logic [15:0] w);
    @(negedge clk);
    bus_if.imem_we    = 1'b1;
    bus_if.imem_waddr = 8'(addr);
    bus_if.imem_wdata = w;
    @(negedge clk);
    bus_if.imem_we    = 1'b0;
  endtask

  task automatic wait_halt(output int cyc);
    cyc = 0;
    while (!bus_if.halted && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_prog(output int cyc);
    @(negedge clk);
    bus_if.run = 1'b1;
    @(negedge clk);
    bus_if.run = 1'b0;
    wait_halt(cyc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_if.run = 1'b0;
    bus_if.imem_we = 1'b0;
    bus_if.imem_waddr = '0;
    bus_if.imem_wdata = '0;
    bus_if.dbg_reg_addr = '0;
    bus_if.dbg_dmem_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_pc", 32'(bus_if.pc), 0);
    chk("rst_busy", 32'(bus_if.busy), 0);
    chk("rst_halted", 32'(bus_if.halted), 0);
    chk("rst_ovf", 32'(bus_if.ovf), 0);
    chk("rst_retired", bus_if.retired, 0);
    chk_reg("rst_r1", 1, 0);

    // Two ADDIs then HALT
    put(0, f_i(3'b001, 1, 0, 5));
    put(1, f_i(3'b001, 2, 1, -3));
    put(2, HALT);
    run_prog(n);
    chk("t1_cycles", 32'(n), 11);
    chk("t1_halted", 32'(bus_if.halted), 1);
    chk_reg("t1_r1", 1, 5);
    chk_reg("t1_r2", 2, 2);
    chk("t1_retired", bus_if.retired, 3);
    chk("t1_pc", 32'(bus_if.pc), 3);
    chk("t1_busy", 32'(bus_if.busy), 0);

    // SW/LW round trip
    put(0, f_i(3'b001, 1, 0, 63));
    put(1, f_i(3'b001, 1, 1, 63));
    put(2, f_i(3'b011, 1, 0, 4));
    put(3, f_i(3'b010, 3, 0, 4));
    put(4, HALT);
    run_prog(n);
    chk("t2_cycles", 32'(n), 20);
    chk_mem("t2_dmem4", 4, 126);
    chk_reg("t2_r3", 3, 126);
    chk("t2_retired", bus_if.retired, 5);
    chk("t2_pc", 32'(bus_if.pc), 5);

    // BEQ taken
    do_reset();
    put(0, f_i(3'b100, 0, 0, 2));
    put(1, f_i(3'b001, 1, 0, 1));
    put(2, f_i(3'b001, 1, 0, 1));
    put(3, f_i(3'b001, 2, 0, 7));
    put(4, HALT);
    run_prog(n);
    chk("t3_cycles", 32'(n), 10);
    chk_reg("t3_r1", 1, 0);
    chk_reg("t3_r2", 2, 7);
    chk("t3_retired", bus_if.retired, 3);
    chk("t3_pc", 32'(bus_if.pc), 5);

    // BEQ not taken
    put(0, f_i(3'b001, 1, 0, 1));
    put(1, f_i(3'b100, 1, 0, 2));
    put(2, f_i(3'b001, 5, 0, 1));
    put(3, f_i(3'b001, 6, 0, 2));
    put(4, HALT);
    run_prog(n);
    chk("t3n_cycles", 32'(n), 18);
    chk_reg("t3n_r5", 5, 1);
    chk_reg("t3n_r6", 6, 2);
    chk("t3n_retired", bus_if.retired, 5);

    // JMP
    put(0, 16'hA003);
    put(1, HALT);
    put(2, HALT);
    put(3, f_i(3'b001, 7, 0, 9));
    put(4, HALT);
    run_prog(n);
    chk("jmp_cycles", 32'(n), 10);
    chk_reg("jmp_r7", 7, 9);
    chk("jmp_pc", 32'(bus_if.pc), 5);
    chk("jmp_retired", bus_if.retired, 3);

    // Build 0x7FFF without overflow: 1 doubled 14x = 0x4000, + 0x3FFF
    put(0, f_i(3'b001, 1, 0, 1));
    for (int i = 1; i <= 14; i++) put(i, f_r(0, 1, 1, 1));
    put(15, f_i(3'b001, 2, 1, -1));
    put(16, f_r(0, 2, 1, 2));
    put(17, HALT);
    run_prog(n);
    chk("t4_halted", 32'(bus_if.halted), 1);
    chk_reg("t4_r1", 1, 32'h4000);
    chk_reg("t4_r2", 2, 32'h7FFF);
    chk("t4_ovf_clear", 32'(bus_if.ovf), 0);

    put(0, f_r(0, 3, 2, 2));
    put(1, f_i(3'b001, 4, 0, 1));
    put(2, HALT);
    run_prog(n);
    chk_reg("t4_add_r3", 3, 32'hFFFE);
    chk_reg("t4_addi_r4", 4, 1);
    chk("t4_ovf_sticky", 32'(bus_if.ovf), 1);

    put(0, HALT);
    run_prog(n);
    chk("t4_ovf_run_clr", 32'(bus_if.ovf), 0);
    chk("t4_halt_retired", bus_if.retired, 1);
    chk("t4_halt_pc", 32'(bus_if.pc), 1);

    put(0, f_r(1, 5, 3, 2));
    put(1, HALT);
    run_prog(n);
    chk_reg("sub_r5", 5, 32'h7FFF);
    chk("sub_ovf", 32'(bus_if.ovf), 1);

    put(0, f_r(2, 6, 2, 3));
    put(1, f_r(3, 7, 2, 3));
    put(2, f_r(1, 4, 2, 2));
    put(3, HALT);
    run_prog(n);
    chk_reg("and_r6", 6, 32'h7FFE);
    chk_reg("or_r7", 7, 32'hFFFF);
    chk_reg("sub0_r4", 4, 0);
    chk("logic_ovf", 32'(bus_if.ovf), 0);

    // R0 write discard, SLT, imem write coinciding with run
    put(0, HALT);
    put(1, f_i(3'b001, 4, 0, -1));
    put(2, f_i(3'b001, 5, 0, 1));
    put(3, f_slt(3, 4, 5));
    put(4, f_slt(6, 5, 4));
    put(5, HALT);
    @(negedge clk);
    bus_if.imem_we    = 1'b1;
    bus_if.imem_waddr = 8'd0;
    bus_if.imem_wdata = f_i(3'b001, 0, 0, 9);
    bus_if.run        = 1'b1;
    @(negedge clk);
    bus_if.imem_we    = 1'b0;
    bus_if.run        = 1'b0;
    wait_halt(n);
    chk("t5_retired", bus_if.retired, 6);
    chk_reg("t5_r0", 0, 0);
    chk_reg("t5_r4", 4, 32'hFFFF);
    chk_reg("t5_slt_r3", 3, 1);
    chk_reg("t5_slt_r6", 6, 0);

    // Reset during WB of ADDI R1,R0,5
    do_reset();
    put(0, f_i(3'b001, 1, 0, 5));
    put(1, HALT);
    @(negedge clk);
    bus_if.run = 1'b1;
    @(negedge clk);
    bus_if.run = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_busy_wb", 32'(bus_if.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reg("t6_r1", 1, 0);
    chk("t6_pc", 32'(bus_if.pc), 0);
    chk("t6_busy", 32'(bus_if.busy), 0);
    chk("t6_halted", 32'(bus_if.halted), 0);

    // imem write and run while busy are both ignored
    put(0, f_i(3'b001, 1, 0, 5));
    put(1, f_i(3'b001, 2, 0, 6));
    put(2, HALT);
    put(3, HALT);
    @(negedge clk);
    bus_if.run = 1'b1;
    @(negedge clk);
    bus_if.run = 1'b0;
    @(negedge clk);
    bus_if.imem_we    = 1'b1;
    bus_if.imem_waddr = 8'd2;
    bus_if.imem_wdata = f_i(3'b001, 3, 0, 1);
    bus_if.run        = 1'b1;
    @(negedge clk);
    bus_if.imem_we    = 1'b0;
    bus_if.run        = 1'b0;
    wait_halt(n);
    chk("t6b_cycles", 32'(n), 9);
    chk_reg("t6b_r3", 3, 0);
    chk_reg("t6b_r2", 2, 6);
    chk("t6b_retired", bus_if.retired, 3);
    chk("t6b_pc", 32'(bus_if.pc), 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mips16_multicycle_core.md
Name: mips16_multicycle_core

Overview:
Parametrised multi-cycle successor to the single-cycle 16-bit teaching CPU. It executes a fixed 16-bit instruction format over a DW-bit datapath, using an explicit FSM (FETCH/DECODE/EXECUTE/MEM/WB). It holds internal instruction and data memories, with a load port for instructions and debug read ports for the testbench. It adds R-type ALU ops, LW/SW, BEQ, JMP, SLT, HALT, a sticky overflow flag and a retired-instruction counter.

Parameters:
DW, 16, datapath/register width; must be >= 16.
IMEM_AW, 8, instruction memory address bits; depth is 2^IMEM_AW; PC width is IMEM_AW.
DMEM_AW, 8, data memory address bits; depth is 2^DMEM_AW.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  reset; asynchronous, active-high.
run  in  1  start pulse; honoured only in IDLE or HALTED.
imem_we  in  1  instruction write strobe; ignored unless in IDLE or HALTED.
imem_waddr  in  IMEM_AW  instruction write address.
imem_wdata  in  16  instruction word to write.
dbg_reg_addr  in  3  register index for the debug read.
dbg_reg_data  out  DW  registers[dbg_reg_addr]; combinational.
dbg_dmem_addr  in  DMEM_AW  data memory address for the debug read.
dbg_dmem_data  out  DW  dmem[dbg_dmem_addr]; combinational.
pc  out  IMEM_AW  current program counter.
busy  out  1  high in FETCH, DECODE, EXECUTE, MEM and WB.
halted  out  1  high in HALTED.
ovf  out  1  sticky signed-overflow flag.
retired  out  32  count of completed instructions; wraps.

Behaviour:
- Reset values: pc=0, state=IDLE, busy=0, halted=0, ovf=0, retired=0, R0..R7=0. Memory contents are not reset.
- Reset asserted mid-instruction aborts it; no register or memory write occurs after rst rises.
- Instruction fields: op[15:13], rA[12:10], rB[9:7], rC[2:0], funct[4:3], imm7[6:0]. imm is imm7 sign-extended to DW.
- R0 always reads 0; writes to R0 are discarded.
- Opcodes:
  - 000 R-type: rA = rB op rC, where funct 00=add, 01=sub, 10=and, 11=or.
  - 001 ADDI: rA = rB + imm.
  - 010 LW: rA = dmem[rB+imm].
  - 011 SW: dmem[rB+imm] = rA.
  - 100 BEQ: if rA==rB then pc = pc + imm, using the already-incremented pc.
  - 101 JMP: pc = instr[12:0], zero-extended or truncated to IMEM_AW.
  - 110 SLT: rA = (signed rB < signed rC) ? 1 : 0.
  - 111 HALT.
- Memory addresses use the low DMEM_AW bits of the ALU result. PC arithmetic wraps modulo 2^IMEM_AW.
- FSM transitions:
  - IDLE -> FETCH on run. The transition sets pc=0, retired=0, ovf=0.
  - FETCH: instr <= imem[pc]; pc <= pc+1.
  - DECODE: latch rA/rB/rC operand values and imm.
  - EXECUTE: ALU computes the result or address. BEQ and JMP update pc here and complete. HALT goes to HALTED and completes.
  - MEM: LW reads into the data register then goes to WB. SW writes dmem and completes.
  - WB: writes rA for R-type, ADDI, SLT and LW, then completes.
  - Completing means retired += 1 and the next state is FETCH.
- Cycles per instruction:
  - 3: BEQ, JMP, HALT.
  - 4: R-type, ADDI, SLT, SW.
  - 5: LW.
- HALTED: holds pc (pointing past the HALT) and all state. run behaves as in IDLE. rst -> IDLE.
- ovf sets on signed overflow of ADD, SUB or ADDI in EXECUTE. Signed overflow means the operand signs agree (for SUB: the sign of rB and the negated rC agree) and the result sign differs. ovf clears only on rst or run.
- An imem write and run in the same cycle: the write lands first, so the fetch at pc 0 sees the new word.
- A run pulse while busy is ignored.

Test Plan:
1. Load ADDI R1,R0,5; ADDI R2,R1,-3; HALT; pulse run -> R1=5, R2=2, retired=3, halted=1 after 11 cycles, pc=3.
2. ADDI R1,R0,63; ADDI R1,R1,63; SW R1,[R0+4]; LW R3,[R0+4]; HALT -> dmem[4]=126, R3=126, retired=5.
3. BEQ R0,R0,+2 skipping two ADDI R1,R0,1 instructions, then ADDI R2,R0,7; HALT -> R1=0, R2=7. Repeat with rA=R1 holding 1 (not taken) -> R1 written.
4. DW=16: load 0x7FFF into R1 (via SW/LW or an ADDI sequence), then ADD R2,R1,R1 -> R2=0xFFFE, ovf=1. ovf stays 1 after a following ADDI; clears on the next run.
5. ADDI R0,R0,9 -> R0 reads 0. SLT R3,R4,R5 with R4=-1 and R5=1 -> R3=1.
6. Assert rst during the WB state of ADDI R1,R0,5 -> R1 stays 0, state IDLE, pc=0. imem_we asserted while busy -> the word at that address is unchanged.
